// File: rtl/tx_scheduler.sv
// tx_scheduler: arbitrates power-on replies and keyboard/mouse events onto the
// single serial Sender. Events are framed at push time and buffered in a small
// FIFO. A one-deep output register presents frames on a valid/ready handshake.
// Each frame ends in acceptance or timeout, and a fixed idle gap follows it.
module tx_scheduler #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned GAP      = 4,
   parameter int unsigned TIMEOUT  = 65535,
   parameter logic [39:0] PWR_WORD = 40'hC0_0000_0000,
   parameter logic [7:0]  KB_HDR   = 8'h00,
   parameter logic [7:0]  MS_HDR   = 8'h01
) (
   input  logic                   mon_clk,
   input  logic                   rst_n,
   input  logic                   pwr_on_req,
   input  logic                   kb_valid,
   input  logic                   kb_is_mouse,
   input  logic [15:0]            kb_data,
   input  logic                   tx_ready,
   output logic                   tx_valid,
   output logic [39:0]            tx_data,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   overflow,
   output logic                   drop
);

   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam int unsigned   LW       = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [15:0]   GAP_LAST = 16'(GAP - 1);
   localparam bit            HAS_GAP  = (GAP != 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESENT,
      ST_GAP
   } state_t;

   // Scheduler state and registered outputs
   state_t        state_q;
   logic [15:0]   timer_q;
   logic          tx_valid_q;
   logic [39:0]   tx_data_q;
   logic          overflow_q;
   logic          drop_q;
   logic          pwr_pend_q;

   // FIFO storage and bookkeeping
   logic [39:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   // Per-cycle decisions
   logic [39:0]   push_frame;
   logic [39:0]   head_frame;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pend_any;
   logic          gap_done;
   logic          dispatch;
   logic          take_pwr;
   logic          take_kb;
   logic          bypass;
   logic          do_pop;
   logic          do_push;
   logic          overflow_d;

   // Decide what to load, push and pop this cycle.
   always_comb begin
      push_frame = {(kb_is_mouse ? MS_HDR : KB_HDR), 16'h0000, kb_data};
      fifo_empty = (level_q == '0);
      fifo_full  = (level_q == LVL_FULL);
      // An empty FIFO forwards a same-cycle event straight to the output register.
      // This forwarding gives the one-cycle minimum latency.
      head_frame = fifo_empty ? push_frame : mem_q[rd_ptr_q];
      // A request arriving this cycle counts as pending, so it can be served at once.
      pend_any   = pwr_pend_q | pwr_on_req;
      // The last gap cycle also makes the IDLE decision.
      // This keeps tx_valid low for exactly GAP cycles when work is waiting.
      gap_done   = (state_q == ST_GAP) && (timer_q == GAP_LAST);
      dispatch   = (state_q == ST_IDLE) || gap_done;
      take_pwr   = dispatch && pend_any;
      take_kb    = dispatch && !pend_any && (!fifo_empty || kb_valid);
      bypass     = take_kb && fifo_empty;
      do_pop     = take_kb && !fifo_empty;
      do_push    = kb_valid && !bypass && (!fifo_full || do_pop);
      overflow_d = kb_valid && !bypass && fifo_full && !do_pop;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
         level_d = level_q + LVL_ONE;
      end else if (do_pop && !do_push) begin
         level_d = level_q - LVL_ONE;
      end
   end

   // FIFO storage: write-only array; the head is read into the output register.
   always_ff @(posedge mon_clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_frame;
      end
   end

   // FIFO pointers and occupancy; reset empties the buffer.
   always_ff @(posedge mon_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Scheduler FSM: load, present with timeout, then idle gap.
   always_ff @(posedge mon_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         overflow_q <= 1'b0;
         drop_q     <= 1'b0;
         pwr_pend_q <= 1'b0;
      end else begin
         drop_q     <= 1'b0;
         overflow_q <= overflow_d;
         pwr_pend_q <= pend_any & ~take_pwr;
         if (dispatch) begin
            if (take_pwr) begin
               tx_data_q  <= PWR_WORD;
               tx_valid_q <= 1'b1;
               timer_q    <= '0;
               state_q    <= ST_PRESENT;
            end else if (take_kb) begin
               tx_data_q  <= head_frame;
               tx_valid_q <= 1'b1;
               timer_q    <= '0;
               state_q    <= ST_PRESENT;
            end else begin
               tx_valid_q <= 1'b0;
               timer_q    <= '0;
               state_q    <= ST_IDLE;
            end
         end else begin
            case (state_q)
               ST_PRESENT: begin
                  if (tx_ready) begin
                     tx_valid_q <= 1'b0;
                     timer_q    <= '0;
                     state_q    <= HAS_GAP ? ST_GAP : ST_IDLE;
                  end else if (timer_q == TMO_LAST) begin
                     tx_valid_q <= 1'b0;
                     drop_q     <= 1'b1;
                     timer_q    <= '0;
                     state_q    <= HAS_GAP ? ST_GAP : ST_IDLE;
                  end else begin
                     timer_q <= timer_q + 16'd1;
                  end
               end
               ST_GAP: begin
                  timer_q <= timer_q + 16'd1;
               end
               default: begin
                  tx_valid_q <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign tx_valid   = tx_valid_q;
   assign tx_data    = tx_data_q;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign drop       = drop_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: directed stimulus for tx_scheduler. Expected frames are
// queued as they are issued. A negedge monitor pops the queue and compares on
// every accept or drop.
module tb_tx_scheduler;

   localparam logic [39:0] PWR_WORD = 40'hC0_0000_0000;

   typedef struct packed {
      logic        is_drop;
      logic [39:0] frame;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        pwr_on_req;
   logic        kb_valid;
   logic        kb_is_mouse;
   logic [15:0] kb_data;
   logic        tx_ready;
   logic        tx_valid;
   logic [39:0] tx_data;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        drop;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];

   // Test 3 vectors: data, mouse flag, expected frame, dropped later.
   logic [15:0] t3_data  [6] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
   logic        t3_mouse [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [39:0] t3_frame [6] = '{40'h01_0000_0001, 40'h00_0000_0002, 40'h01_0000_0003,
                                 40'h00_0000_0004, 40'h01_0000_0005, 40'h00_0000_0006};
   logic        t3_drop  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   tx_scheduler dut (
      .mon_clk     (clk),
      .rst_n       (rst_n),
      .pwr_on_req  (pwr_on_req),
      .kb_valid    (kb_valid),
      .kb_is_mouse (kb_is_mouse),
      .kb_data     (kb_data),
      .tx_ready    (tx_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .drop        (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one scoreboard pop per accepted or dropped frame.
   logic        prev_valid = 1'b0;
   logic [39:0] first_data = '0;
   logic [39:0] last_data  = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (tx_valid && !prev_valid) first_data = tx_data;
         if (tx_valid) last_data = tx_data;
         if (tx_valid && tx_ready) begin
            $display("accept frame %010h", tx_data);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL accept_unexpected: got frame %010h, expected none", tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("accept_kind", 64'(e.is_drop), 64'(0));
               chk("accept_data", 64'(tx_data), 64'(e.frame));
               chk("accept_hold", 64'(tx_data), 64'(first_data));
            end
         end
         if (drop) begin
            $display("drop frame %010h", last_data);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL drop_unexpected: got drop of %010h, expected none", last_data);
            end else begin
               e = exp_q.pop_front();
               chk("drop_kind", 64'(e.is_drop), 64'(1));
               chk("drop_data", 64'(last_data), 64'(e.frame));
            end
         end
         prev_valid = tx_valid;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #(10 * 80000);
      errors++;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      pwr_on_req  = 1'b0;
      kb_valid    = 1'b0;
      kb_is_mouse = 1'b0;
      kb_data     = '0;
      tx_ready    = 1'b0;
      tick();
      tick();
      chk("rst_valid", 64'(tx_valid), 64'(0));
      chk("rst_data", 64'(tx_data), 64'(0));
      chk("rst_level", 64'(fifo_level), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_drop", 64'(drop), 64'(0));
      rst_n = 1'b1;
      tick();
      tick();

      // Test 1: a single keyboard event, with one-cycle latency, held until ready.
      kb_valid = 1'b1; kb_data = 16'h1234; kb_is_mouse = 1'b0;
      exp_q.push_back('{1'b0, 40'h00_0000_1234});
      tick();
      kb_valid = 1'b0;
      chk("t1_latency_valid", 64'(tx_valid), 64'(1));
      chk("t1_data", 64'(tx_data), 64'h00_0000_1234);
      chk("t1_level", 64'(fifo_level), 64'(0));
      repeat (3) tick();
      chk("t1_hold_valid", 64'(tx_valid), 64'(1));
      chk("t1_hold_data", 64'(tx_data), 64'h00_0000_1234);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("t1_after_accept", 64'(tx_valid), 64'(0));
      repeat (6) tick();

      // Test 2: power-on wins over a same-cycle keyboard event.
      pwr_on_req = 1'b1;
      kb_valid = 1'b1; kb_data = 16'hABCD; kb_is_mouse = 1'b1;
      exp_q.push_back('{1'b0, PWR_WORD});
      exp_q.push_back('{1'b0, 40'h01_0000_ABCD});
      tick();
      pwr_on_req = 1'b0;
      kb_valid = 1'b0;
      chk("t2_pwr_valid", 64'(tx_valid), 64'(1));
      chk("t2_pwr_data", 64'(tx_data), 64'(PWR_WORD));
      chk("t2_level", 64'(fifo_level), 64'(1));
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t2_gap_low", 64'(tx_valid), 64'(0));
         tick();
      end
      chk("t2_kb_valid", 64'(tx_valid), 64'(1));
      chk("t2_kb_data", 64'(tx_data), 64'h01_0000_ABCD);
      chk("t2_level_after", 64'(fifo_level), 64'(0));
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      repeat (6) tick();

      // Test 3: six pushes with no ready: one presented, four stored, one lost.
      for (int i = 0; i < 6; i++) begin
         kb_valid = 1'b1; kb_data = t3_data[i]; kb_is_mouse = t3_mouse[i];
         if (i < 5) exp_q.push_back('{t3_drop[i], t3_frame[i]});
         tick();
      end
      kb_valid = 1'b0;
      chk("t3_overflow_pulse", 64'(overflow), 64'(1));
      chk("t3_level_full", 64'(fifo_level), 64'(4));
      chk("t3_presented", 64'(tx_data), 64'(t3_frame[0]));
      tick();
      chk("t3_overflow_clear", 64'(overflow), 64'(0));
      chk("t3_level_still", 64'(fifo_level), 64'(4));

      // Test 4: push in the same cycle as the pop of a full FIFO.
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      repeat (3) tick();
      kb_valid = 1'b1; kb_data = 16'h0007; kb_is_mouse = 1'b0;
      tick();
      kb_valid = 1'b0;
      chk("t4_valid", 64'(tx_valid), 64'(1));
      chk("t4_head", 64'(tx_data), 64'(t3_frame[1]));
      chk("t4_level", 64'(fifo_level), 64'(4));
      chk("t4_no_overflow", 64'(overflow), 64'(0));

      // Test 5: timeout drops the presented frame, then the gap, then the next frame.
      // The 0x0007 event is queued after the test-3 frames, which are already queued.
      exp_q.push_back('{1'b0, 40'h00_0000_0007});
      repeat (65534) tick();
      chk("t5_pre_timeout_valid", 64'(tx_valid), 64'(1));
      chk("t5_pre_timeout_drop", 64'(drop), 64'(0));
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t5_gap_low", 64'(tx_valid), 64'(0));
         chk("t5_drop_pulse", 64'(drop), 64'(i == 0));
         tick();
      end
      chk("t5_next_valid", 64'(tx_valid), 64'(1));
      chk("t5_next_data", 64'(tx_data), 64'(t3_frame[2]));
      tx_ready = 1'b1;
      repeat (40) tick();
      tx_ready = 1'b0;
      chk("t5_drained_level", 64'(fifo_level), 64'(0));
      chk("t5_scoreboard_empty", 64'(exp_q.size()), 64'(0));

      // Test 6: reset during PRESENT discards everything.
      kb_valid = 1'b1; kb_data = 16'h0008; kb_is_mouse = 1'b0;
      tick();
      kb_data = 16'h0009;
      tick();
      kb_data = 16'h000A; pwr_on_req = 1'b1;
      tick();
      kb_valid = 1'b0; pwr_on_req = 1'b0;
      chk("t6_pre_valid", 64'(tx_valid), 64'(1));
      chk("t6_pre_level", 64'(fifo_level), 64'(2));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(tx_valid), 64'(0));
      chk("t6_rst_level", 64'(fifo_level), 64'(0));
      chk("t6_rst_drop", 64'(drop), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t6_post_valid", 64'(tx_valid), 64'(0));
         chk("t6_post_drop", 64'(drop), 64'(0));
      end
      chk("t6_post_level", 64'(fifo_level), 64'(0));
      chk("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
